// File: rtl/spoc_pkg.sv
// SpoC-64 shared definitions: loader FSM encoding, block geometry,
// segment type codes and the padding byte shared with the datapath.
package spoc_pkg;

  localparam int PW        = 32;
  localparam int BLK_BYTES = 8;
  localparam int BLK_W     = 8 * BLK_BYTES;

  typedef enum logic [1:0] {
    FILL_HI = 2'd0,
    FILL_LO = 2'd1,
    HOLD    = 2'd2
  } state_t;

  localparam logic [2:0] AD_TYPE  = 3'b001;
  localparam logic [2:0] MSG_TYPE = 3'b010;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  function automatic logic [2:0] clamp_size(
    input logic [2:0] s
  );
    return (s > 3'd4) ? 3'd4 : s;
  endfunction

endpackage

// File: rtl/spoc_bdi_loader_if.sv
// Word-in / block-out handshake bundle of the SpoC-64 BDI loader.
// slave is the loader's view, master is the controller/datapath side.
interface spoc_bdi_loader_if;

  logic [31:0] bdi;
  logic        bdi_valid;
  logic        bdi_ready;
  logic [2:0]  bdi_size;
  logic        bdi_eot;
  logic [2:0]  bdi_type;
  logic        req_empty;
  logic [2:0]  empty_type;
  logic        clr;

  logic [63:0] blk;
  logic        blk_valid;
  logic        blk_ready;
  logic [3:0]  blk_size;
  logic        blk_partial;
  logic        blk_last;
  logic [2:0]  blk_type;
  logic        err;

  modport slave (
    input  bdi, bdi_valid, bdi_size, bdi_eot, bdi_type,
    input  req_empty, empty_type, clr, blk_ready,
    output bdi_ready, blk, blk_valid, blk_size,
    output blk_partial, blk_last, blk_type, err
  );

  modport master (
    output bdi, bdi_valid, bdi_size, bdi_eot, bdi_type,
    output req_empty, empty_type, clr, blk_ready,
    input  bdi_ready, blk, blk_valid, blk_size,
    input  blk_partial, blk_last, blk_type, err
  );

endinterface

// File: rtl/spoc_byte_mask.sv
// Left-aligned byte mask for a 0..7 byte count; counts above 4 saturate
// to a full word so oversize words are absorbed as 4 bytes.
module spoc_byte_mask
  import spoc_pkg::*;
(
  input  logic [2:0]    size,
  output logic [PW-1:0] mask
);

  always_comb begin
    mask = '0;
    unique case (1'b1)
      (size == 3'd0): mask = 32'h0000_0000;
      (size == 3'd1): mask = 32'hFF00_0000;
      (size == 3'd2): mask = 32'hFFFF_0000;
      (size == 3'd3): mask = 32'hFFFF_FF00;
      (size >= 3'd4): mask = 32'hFFFF_FFFF;
    endcase
  end

endmodule

// File: rtl/spoc_bdi_loader.sv
// Packs the 32-bit BDI word stream into 64-bit rate blocks with byte
// count, partial/last flags and type, one block per datapath absorb.
module spoc_bdi_loader
  import spoc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  spoc_bdi_loader_if.slave io
);

  state_t            state;
  state_t            state_n;
  logic              rdy_q;
  logic [BLK_W-1:0]  blk_q;
  logic [3:0]        size_q;
  logic              last_q;
  logic [2:0]        type_q;
  logic              err_q;

  logic [PW-1:0]     mask;
  logic [PW-1:0]     word;
  logic [2:0]        eff;
  logic              take;
  logic              go_empty;
  logic              short_w;
  logic              bad;

  spoc_byte_mask u_mask (
    .size (io.bdi_size),
    .mask (mask)
  );

  assign word = io.bdi & mask;
  assign eff  = clamp_size(io.bdi_size);

  // rdy_q keeps bdi_ready low until the first edge after reset release
  assign io.bdi_ready = rdy_q & (state != HOLD) & ~io.clr;
  assign take         = io.bdi_valid & io.bdi_ready;
  assign go_empty     = (state == FILL_HI) & io.req_empty
                      & ~io.bdi_valid;
  assign short_w      = io.bdi_eot | (eff < 3'd4);

  assign bad = take & (
    (io.bdi_size == 3'd0) | (io.bdi_size > 3'd4) |
    ((state == FILL_LO) & (io.bdi_type != type_q))
  );

  always_comb begin
    state_n = state;
    unique case (state)
      FILL_HI: begin
        if (take)
          state_n = short_w ? HOLD : FILL_LO;
        else if (go_empty)
          state_n = HOLD;
      end
      FILL_LO: if (take) state_n = HOLD;
      HOLD:    if (io.blk_ready) state_n = FILL_HI;
      default: state_n = FILL_HI;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rdy_q <= 1'b0;
    else
      rdy_q <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= FILL_HI;
    else if (io.clr)
      state <= FILL_HI;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blk_q  <= '0;
      size_q <= '0;
      last_q <= 1'b0;
      type_q <= '0;
      err_q  <= 1'b0;
    end else if (io.clr) begin
      blk_q  <= '0;
      size_q <= '0;
      last_q <= 1'b0;
      type_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (bad)
        err_q <= 1'b1;
      unique case (state)
        FILL_HI: begin
          if (take) begin
            blk_q  <= {word, 32'h0};
            size_q <= {1'b0, eff};
            type_q <= io.bdi_type;
            last_q <= io.bdi_eot;
          end else if (go_empty) begin
            blk_q  <= '0;
            size_q <= '0;
            type_q <= io.empty_type;
            last_q <= 1'b1;
          end
        end
        FILL_LO: begin
          if (take) begin
            blk_q[31:0] <= word;
            size_q      <= size_q + {1'b0, eff};
            last_q      <= io.bdi_eot;
          end
        end
        HOLD: begin
          if (io.blk_ready) begin
            blk_q  <= '0;
            size_q <= '0;
            last_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.blk         = blk_q;
  assign io.blk_valid   = (state == HOLD);
  assign io.blk_size    = size_q;
  // partial only qualifies a presented block; idle/reset reads 0
  assign io.blk_partial = (state == HOLD) & (size_q != 4'd8);
  assign io.blk_last    = last_q;
  assign io.blk_type    = type_q;
  assign io.err         = err_q;

endmodule

// File: tb/tb_spoc_bdi_loader.sv
// Scoreboard bench for spoc_bdi_loader: byte-level reference model,
// randomized word stream, directed reset/clr/empty/error cases.
module tb_spoc_bdi_loader;
  import spoc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  spoc_bdi_loader_if bus ();

  spoc_bdi_loader dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          n;
    bit          last;
    logic [2:0]  t;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] cur;
  int          nb = 0;
  int          nw = 0;
  logic [2:0]  ctype;
  bit          err_m = 0;
  bit          mon_en = 0;
  bit          rdy_rand = 0;
  logic        rdy_force = 1'b0;

  function automatic void check(string nm, logic [63:0] act,
                                logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // bytes of accepted words are appended to the open block; a block
  // closes after two words, on eot, or when its first word is short
  function automatic void model_word(logic [31:0] d, logic [2:0] s,
                                     bit e, logic [2:0] t);
    int eff;
    eff = (s > 3'd4) ? 4 : int'(s);
    if (s == 3'd0 || s > 3'd4) err_m = 1;
    if (nw == 0) begin
      cur = '0;
      nb = 0;
      ctype = t;
    end else if (t != ctype) begin
      err_m = 1;
    end
    for (int i = 0; i < eff; i++) begin
      cur[63-8*nb -: 8] = d[31-8*i -: 8];
      nb++;
    end
    nw++;
    if (nw == 2 || e || eff < 4) begin
      q.push_back('{cur, nb, e, ctype});
      nw = 0;
    end
  endfunction

  always @(posedge clk) begin
    #1;
    bus.blk_ready = rdy_rand ? ($urandom_range(9) < 7) : rdy_force;
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("blk_valid", 64'(bus.blk_valid), 64'(q.size() > 0));
      check("bdi_ready", 64'(bus.bdi_ready),
            64'((q.size() == 0) && !bus.clr));
      check("err", 64'(bus.err), 64'(err_m));
      if (bus.blk_valid && q.size() > 0) begin
        mon_e = q[0];
        check("blk", bus.blk, mon_e.d);
        check("blk_size", 64'(bus.blk_size), 64'(mon_e.n));
        check("blk_partial", 64'(bus.blk_partial), 64'(mon_e.n != 8));
        check("blk_last", 64'(bus.blk_last), 64'(mon_e.last));
        check("blk_type", 64'(bus.blk_type), 64'(mon_e.t));
        if (bus.blk_ready) void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] s,
                           input bit e, input logic [2:0] t,
                           input bit req);
    bit r;
    int k;
    r = 0;
    k = 0;
    bus.bdi = d;
    bus.bdi_size = s;
    bus.bdi_eot = e;
    bus.bdi_type = t;
    bus.bdi_valid = 1'b1;
    bus.req_empty = req;
    bus.empty_type = MSG_TYPE;
    while (!r && k < 200) begin
      @(negedge clk);
      r = bus.bdi_ready;
      @(posedge clk);
      if (r) model_word(d, s, e, t);
      #1;
      k++;
    end
    n_chk++;
    if (!r) begin
      n_fail++;
      $display("FAIL send_timeout: got no bdi_ready expected accept in 200 cycles");
    end
    bus.bdi_valid = 1'b0;
    bus.req_empty = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d blocks pending expected 0", q.size());
    end
  endtask

  task automatic send_empty(input logic [2:0] t);
    wait_drain();
    bus.bdi_valid = 1'b0;
    bus.req_empty = 1'b1;
    bus.empty_type = t;
    @(posedge clk);
    q.push_back('{64'h0, 0, 1'b1, t});
    #1;
    bus.req_empty = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    nw = 0;
    nb = 0;
    err_m = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1);
  end

  initial begin
    logic [2:0]  seg_t;
    logic [2:0]  s;
    logic [2:0]  t;
    logic [31:0] d;
    bit          e;

    bus.bdi = '0;
    bus.bdi_valid = 1'b0;
    bus.bdi_size = 3'd4;
    bus.bdi_eot = 1'b0;
    bus.bdi_type = '0;
    bus.req_empty = 1'b0;
    bus.empty_type = '0;
    bus.clr = 1'b0;
    bus.blk_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_bdi_ready", 64'(bus.bdi_ready), 64'd0);
    check("rst_blk_valid", 64'(bus.blk_valid), 64'd0);
    check("rst_blk", bus.blk, 64'd0);
    check("rst_blk_size", 64'(bus.blk_size), 64'd0);
    check("rst_blk_partial", 64'(bus.blk_partial), 64'd0);
    check("rst_blk_last", 64'(bus.blk_last), 64'd0);
    check("rst_blk_type", 64'(bus.blk_type), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rel_ready_early", 64'(bus.bdi_ready), 64'd0);
    @(negedge clk);
    check("rel_ready", 64'(bus.bdi_ready), 64'd1);
    @(posedge clk);
    #1;
    mon_en = 1;
    rdy_rand = 1;

    send_word(32'h01020304, 3'd4, 1'b0, AD_TYPE, 1'b0);
    send_word(32'h05060708, 3'd4, 1'b1, AD_TYPE, 1'b0);
    send_word(32'hAABBCCDD, 3'd2, 1'b1, MSG_TYPE, 1'b0);
    send_word(32'h11223344, 3'd4, 1'b0, MSG_TYPE, 1'b0);
    send_word(32'h55667788, 3'd3, 1'b0, MSG_TYPE, 1'b0);
    send_word(32'h99AABBCC, 3'd3, 1'b0, AD_TYPE, 1'b0);
    send_empty(MSG_TYPE);
    wait_drain();
    send_word(32'hCAFEBABE, 3'd2, 1'b1, AD_TYPE, 1'b1);
    wait_drain();

    seg_t = AD_TYPE;
    for (int it = 0; it < 400; it++) begin
      if (nw == 0 && $urandom_range(19) == 0) begin
        send_empty($urandom_range(1) ? AD_TYPE : MSG_TYPE);
      end else begin
        s = ($urandom_range(9) < 6) ? 3'd4 : 3'($urandom_range(3, 1));
        if ($urandom_range(29) == 0)
          s = 3'd0;
        else if ($urandom_range(29) == 0)
          s = 3'($urandom_range(7, 5));
        t = seg_t;
        if ($urandom_range(29) == 0) t = seg_t ^ 3'b011;
        d = $urandom;
        e = ($urandom_range(4) == 0);
        send_word(d, s, e, t, 1'b0);
        if (e) seg_t = $urandom_range(1) ? AD_TYPE : MSG_TYPE;
      end
      idle($urandom_range(2));
    end
    if (nw != 0) send_word(32'h0F0F0F0F, 3'd4, 1'b1, seg_t, 1'b0);
    wait_drain();

    send_word(32'hFFFFFFFF, 3'd0, 1'b0, MSG_TYPE, 1'b0);
    wait_drain();
    rdy_rand = 0;
    rdy_force = 1'b0;
    idle(1);
    send_word(32'h12345678, 3'd4, 1'b1, AD_TYPE, 1'b0);
    idle(10);
    mon_en = 0;
    bus.clr = 1'b1;
    @(negedge clk);
    check("clr_bdi_ready", 64'(bus.bdi_ready), 64'd0);
    check("clr_err_before", 64'(bus.err), 64'd1);
    @(posedge clk);
    #1 bus.clr = 1'b0;
    check("clr_blk_valid", 64'(bus.blk_valid), 64'd0);
    check("clr_err", 64'(bus.err), 64'd0);
    check("clr_blk", bus.blk, 64'd0);
    check("clr_blk_size", 64'(bus.blk_size), 64'd0);
    model_reset();
    @(negedge clk);
    check("clr_ready_after", 64'(bus.bdi_ready), 64'd1);
    mon_en = 1;
    rdy_rand = 1;
    @(posedge clk);
    #1;

    send_word(32'hA1A2A3A4, 3'd4, 1'b0, AD_TYPE, 1'b0);
    send_word(32'hB1B2B3B4, 3'd4, 1'b1, MSG_TYPE, 1'b0);
    wait_drain();
    send_word(32'h0BADF00D, 3'd4, 1'b0, AD_TYPE, 1'b0);
    mon_en = 0;
    #2 rst = 1'b0;
    #1;
    check("arst_bdi_ready", 64'(bus.bdi_ready), 64'd0);
    check("arst_blk_valid", 64'(bus.blk_valid), 64'd0);
    check("arst_blk", bus.blk, 64'd0);
    check("arst_blk_size", 64'(bus.blk_size), 64'd0);
    check("arst_err", 64'(bus.err), 64'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("arst_ready_after", 64'(bus.bdi_ready), 64'd1);
    @(posedge clk);
    #1;
    mon_en = 1;
    send_word(32'hDEADBEEF, 3'd4, 1'b0, MSG_TYPE, 1'b0);
    send_word(32'h00C0FFEE, 3'd1, 1'b1, MSG_TYPE, 1'b0);
    wait_drain();
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spoc_bdi_loader.md
Name: spoc_bdi_loader

Overview:
- Upstream neighbour of the SpoC-64 datapath: turns the 32-bit public-data word stream into 64-bit rate blocks, one block per datapath absorb.
- Per block it records the byte count (0..8), partial flag, last flag and data type.
- Bytes beyond the valid count are zero-masked, so the datapath's 10* padding logic sees clean data.
- It hands blocks downstream with a valid/ready handshake and also issues empty (size-0) blocks on controller request.

Parameters:
PW, 32, input word width in bits (fixed; 4 bytes, big-endian, left-aligned)
BLK_BYTES, 8, rate block size in bytes (block width = 8*BLK_BYTES = 64)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-low (rst=0 resets)
bdi  in  32  data word, byte 0 in [31:24]
bdi_valid  in  1  word present
bdi_ready  out  1  word accepted when bdi_valid & bdi_ready
bdi_size  in  3  valid bytes in word, 1..4
bdi_eot  in  1  word is last of its segment
bdi_type  in  3  segment type (AD / msg), constant within a segment
req_empty  in  1  controller request for an empty padded block
empty_type  in  3  type tagged on the empty block
clr  in  1  synchronous flush
blk  out  64  assembled block, word 0 in [63:32]
blk_valid  out  1  block available
blk_ready  in  1  datapath consumes block
blk_size  out  4  valid bytes, 0..8
blk_partial  out  1  blk_size < 8
blk_last  out  1  block ends a segment (eot seen, or empty block)
blk_type  out  3  type latched from first word
err  out  1  sticky protocol error

Behaviour:
Reset (rst=0, async) and clr (sync) have the same effect:
- state FILL_HI; blk=0; blk_size=0; blk_partial=0; blk_last=0; blk_type=0; blk_valid=0; err=0.
- bdi_ready is 0 while rst=0. It is 1 on the first edge after release.

FSM states FILL_HI, FILL_LO, HOLD, registered.
- bdi_ready = (state != HOLD) & ~clr.
- blk_valid = (state == HOLD).
- No combinational path from bdi_valid or blk_ready to any output.

Masking:
- Incoming word is ANDed with a byte mask, bytes 0..bdi_size-1 kept, rest zero.
- The mask comes from the sub-module.

FILL_HI, on accepted word:
- blk[63:32] <= masked word; blk[31:0] <= 0; blk_size <= bdi_size; blk_type <= bdi_type.
- If bdi_eot=1 or bdi_size<4: blk_last <= bdi_eot; go HOLD.
- Otherwise go FILL_LO.

FILL_HI, req_empty:
- Honoured only when bdi_valid=0; an arriving word has priority.
- blk <= 0; blk_size <= 0; blk_last <= 1; blk_type <= empty_type; go HOLD.
- The controller holds req_empty until blk_valid is seen.
- req_empty is ignored in any other state.

FILL_LO, on accepted word:
- blk[31:0] <= masked word; blk_size <= blk_size + bdi_size (4-bit, max 8, never wraps); blk_last <= bdi_eot; go HOLD.

HOLD:
- Outputs stable until blk_valid & blk_ready.
- On that cycle: go FILL_HI; blk and blk_size cleared next cycle.
- Throughput is one full block per 3 cycles minimum (2 fill + 1 hold). The bubble is intended.

blk_partial = (blk_size != 8), combinational from the register.

err, set (sticky until rst/clr) when an accepted word has:
- bdi_size = 0 or bdi_size > 4: the word is still absorbed, with its size clamped to 4 if >4 and treated as 0 bytes if 0; or
- in FILL_LO, bdi_type differs from the latched blk_type: the word is still absorbed.

clr asserted in HOLD drops the held block; the datapath must not sample it that cycle.

Reset mid-block: partial data is lost. No output glitch beyond the asynchronous clear.

Decomposition:
- Shared package spoc_pkg:
  - FSM state encoding (2 bits: FILL_HI=0, FILL_LO=1, HOLD=2);
  - BLK_BYTES;
  - type codes AD_TYPE=3'b001, MSG_TYPE=3'b010;
  - PAD_BYTE=8'h80, which the datapath also uses.
- Sub-module spoc_byte_mask: combinational bdi_size -> 32-bit left-aligned byte mask. It is reused by the output truncation path.

Test Plan:
1. Full block: words 0x01020304 (size 4) then 0x05060708 (size 4, eot=1), type 001 -> one cycle after the second word blk_valid=1, blk=0x0102030405060708, blk_size=8, partial=0, last=1, type=001.
2. Short tail: word 0xAABBCCDD size 2, eot=1 -> blk=0xAABB000000000000, size=2, partial=1, last=1; bdi_ready=0 until blk_ready pulse, then 1 the next cycle.
3. Mid-block partial: word 0x11223344 size 4, then 0x55667788 size 3, eot=0 -> blk=0x1122334455667700, size=7, last=0; a partial first word (size 3, eot=0) closes the block immediately with size=3.
4. Empty block: idle input, req_empty=1, empty_type=010 -> blk_valid next cycle with blk=0, size=0, partial=1, last=1, type=010; with bdi_valid asserted in the same cycle the word is taken instead.
5. Backpressure/clr: hold blk_ready=0 for 10 cycles -> blk stable, bdi_ready=0 throughout; assert clr in HOLD -> blk_valid=0 and err=0 next cycle, state FILL_HI.
6. Errors and reset: word size 0 -> err=1 and stays 1; word in FILL_LO with type 010 after 001 -> err=1; async rst=0 mid-FILL_LO -> all outputs 0 immediately, bdi_ready=1 after release.
